// File: rtl/sensor_pwr_seq.sv
// Power-up/power-down sequencer for the SLVS-EC sensor: drives rails, INCK and XCLR
// in a fixed order with per-step dwell counts, from a single pwr_req level.
module sensor_pwr_seq #(
    parameter int CNT_W   = 24,
    parameter int T_RAIL  = 5000,
    parameter int T_INCK  = 5000,
    parameter int T_XCLR  = 1000,
    parameter int T_READY = 50000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       pwr_req,
    output logic       reg_3v3_en_o,
    output logic       reg_1v8_en_o,
    output logic       reg_1v2_en_o,
    output logic       inck_en_o,
    output logic       xclr_o,
    output logic       pwr_good,
    output logic       busy,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_OFF    = 4'd0,
        S_U3V3   = 4'd1,
        S_U1V8   = 4'd2,
        S_U1V2   = 4'd3,
        S_UINCK  = 4'd4,
        S_UXCLR  = 4'd5,
        S_ON     = 4'd6,
        S_D_XCLR = 4'd7,
        S_D_INCK = 4'd8,
        S_D_1V2  = 4'd9,
        S_D_1V8  = 4'd10,
        S_D_3V3  = 4'd11
    } state_t;

    localparam logic [CNT_W-1:0] RAIL_LAST  = CNT_W'(T_RAIL - 1);
    localparam logic [CNT_W-1:0] INCK_LAST  = CNT_W'(T_INCK - 1);
    localparam logic [CNT_W-1:0] XCLR_LAST  = CNT_W'(T_XCLR - 1);
    localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(T_READY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dwell_last;
    logic             done;
    logic             r3v3_q, r3v3_d, r1v8_q, r1v8_d, r1v2_q, r1v2_d;
    logic             inck_q, inck_d, xclr_q, xclr_d, good_q, good_d, busy_q, busy_d;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            r3v3_q  <= 1'b0;
            r1v8_q  <= 1'b0;
            r1v2_q  <= 1'b0;
            inck_q  <= 1'b0;
            xclr_q  <= 1'b0;
            good_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r3v3_q  <= r3v3_d;
            r1v8_q  <= r1v8_d;
            r1v2_q  <= r1v2_d;
            inck_q  <= inck_d;
            xclr_q  <= xclr_d;
            good_q  <= good_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        dwell_last = RAIL_LAST;
        case (state_q)
            S_U1V2:  dwell_last = INCK_LAST;
            S_UINCK: dwell_last = XCLR_LAST;
            S_UXCLR: dwell_last = READY_LAST;
            default: dwell_last = RAIL_LAST;
        endcase
        done = (cnt_q == dwell_last);

        // Dropping pwr_req in a U* state preempts the dwell and tears down only what is on.
        state_d = state_q;
        case (state_q)
            S_OFF:    if (pwr_req) state_d = S_U3V3;
            S_U3V3:   if (!pwr_req) state_d = S_D_3V3;  else if (done) state_d = S_U1V8;
            S_U1V8:   if (!pwr_req) state_d = S_D_1V8;  else if (done) state_d = S_U1V2;
            S_U1V2:   if (!pwr_req) state_d = S_D_1V2;  else if (done) state_d = S_UINCK;
            S_UINCK:  if (!pwr_req) state_d = S_D_INCK; else if (done) state_d = S_UXCLR;
            S_UXCLR:  if (!pwr_req) state_d = S_D_XCLR; else if (done) state_d = S_ON;
            S_ON:     if (!pwr_req) state_d = S_D_XCLR;
            S_D_XCLR: if (done) state_d = S_D_INCK;
            S_D_INCK: if (done) state_d = S_D_1V2;
            S_D_1V2:  if (done) state_d = S_D_1V8;
            S_D_1V8:  if (done) state_d = S_D_3V3;
            S_D_3V3:  if (done) state_d = S_OFF;
            default:  state_d = S_D_XCLR;
        endcase

        cnt_d = '0;
        if (state_d == state_q && state_q != S_OFF && state_q != S_ON) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Outputs are set/cleared on state entry so an illegal-state recovery never raises a rail.
        r3v3_d = r3v3_q;
        r1v8_d = r1v8_q;
        r1v2_d = r1v2_q;
        inck_d = inck_q;
        xclr_d = xclr_q;
        good_d = good_q;
        if (state_d != state_q) begin
            case (state_d)
                S_U3V3:   r3v3_d = 1'b1;
                S_U1V8:   r1v8_d = 1'b1;
                S_U1V2:   r1v2_d = 1'b1;
                S_UINCK:  inck_d = 1'b1;
                S_UXCLR:  xclr_d = 1'b1;
                S_ON:     good_d = 1'b1;
                S_D_XCLR: begin
                    xclr_d = 1'b0;
                    good_d = 1'b0;
                end
                S_D_INCK: inck_d = 1'b0;
                S_D_1V2:  r1v2_d = 1'b0;
                S_D_1V8:  r1v8_d = 1'b0;
                S_D_3V3:  r3v3_d = 1'b0;
                default:  ;
            endcase
        end
        busy_d = (state_d != S_OFF) && (state_d != S_ON);
    end

    assign reg_3v3_en_o = r3v3_q;
    assign reg_1v8_en_o = r1v8_q;
    assign reg_1v2_en_o = r1v2_q;
    assign inck_en_o    = inck_q;
    assign xclr_o       = xclr_q;
    assign pwr_good     = good_q;
    assign busy         = busy_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_sensor_pwr_seq.sv
// Directed bench for sensor_pwr_seq with short dwells (T_RAIL=4, T_INCK=3, T_XCLR=5, T_READY=6).
module tb_sensor_pwr_seq;

    localparam int ST_OFF = 0, ST_U3V3 = 1, ST_U1V8 = 2, ST_U1V2 = 3, ST_UINCK = 4, ST_UXCLR = 5;
    localparam int ST_ON = 6, ST_DXCLR = 7, ST_DINCK = 8, ST_D1V2 = 9, ST_D1V8 = 10, ST_D3V3 = 11;

    logic       clk_clk;
    logic       reset_reset_n;
    logic       pwr_req;
    logic       reg_3v3_en_o, reg_1v8_en_o, reg_1v2_en_o, inck_en_o, xclr_o, pwr_good, busy;
    logic [3:0] state_o;
    logic [10:0] obs_v;

    int n_vec = 0;
    int n_err = 0;

    sensor_pwr_seq #(
        .CNT_W(8), .T_RAIL(4), .T_INCK(3), .T_XCLR(5), .T_READY(6)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .pwr_req(pwr_req),
        .reg_3v3_en_o(reg_3v3_en_o),
        .reg_1v8_en_o(reg_1v8_en_o),
        .reg_1v2_en_o(reg_1v2_en_o),
        .inck_en_o(inck_en_o),
        .xclr_o(xclr_o),
        .pwr_good(pwr_good),
        .busy(busy),
        .state_o(state_o)
    );

    // clock / reset
    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    assign obs_v = {state_o, busy, pwr_good, xclr_o, inck_en_o, reg_1v2_en_o, reg_1v8_en_o, reg_3v3_en_o};

    // Expected {state, busy, pwr_good, xclr, inck, 1v2, 1v8, 3v3} while dwelling in a state.
    function automatic logic [10:0] exp_vec(input int st);
        logic [5:0] lv;
        logic       b;
        case (st)
            ST_U3V3:  lv = 6'b000001;
            ST_U1V8:  lv = 6'b000011;
            ST_U1V2:  lv = 6'b000111;
            ST_UINCK: lv = 6'b001111;
            ST_UXCLR: lv = 6'b011111;
            ST_ON:    lv = 6'b111111;
            ST_DXCLR: lv = 6'b001111;
            ST_DINCK: lv = 6'b000111;
            ST_D1V2:  lv = 6'b000011;
            ST_D1V8:  lv = 6'b000001;
            default:  lv = 6'b000000;
        endcase
        b = (st != ST_OFF) && (st != ST_ON);
        return {4'(st), b, lv};
    endfunction

    task automatic tick();
        @(posedge clk_clk);
        @(negedge clk_clk);
    endtask

    task automatic chk(input string tag, input logic [10:0] exp);
        n_vec++;
        assert (obs_v === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs_v, exp);
        end
    endtask

    // Advance n cycles, checking each one against the given state's expected outputs.
    task automatic expect_state(input string tag, input int st, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s[%0d]", tag, i), exp_vec(st));
        end
    endtask

    task automatic full_up(input string tag);
        expect_state({tag, "_3v3"}, ST_U3V3, 4);
        expect_state({tag, "_1v8"}, ST_U1V8, 4);
        expect_state({tag, "_1v2"}, ST_U1V2, 3);
        expect_state({tag, "_inck"}, ST_UINCK, 5);
        expect_state({tag, "_xclr"}, ST_UXCLR, 6);
        expect_state({tag, "_on"}, ST_ON, 3);
    endtask

    initial begin
        reset_reset_n = 1'b0;
        pwr_req       = 1'b0;
        #12;
        chk("in_reset", 11'b0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;

        expect_state("idle", ST_OFF, 20);

        // Sub-cycle glitch between edges must be ignored.
        #1 pwr_req = 1'b1;
        #2 pwr_req = 1'b0;
        expect_state("glitch", ST_OFF, 3);

        // Full power-up: req sampled at edge 0, 3V3 at 1 ... pwr_good at 23.
        pwr_req = 1'b1;
        full_up("up");

        // Full power-down from ON: req=0 sampled at edge m.
        pwr_req = 1'b0;
        expect_state("dn_xclr", ST_DXCLR, 4);
        expect_state("dn_inck", ST_DINCK, 4);
        expect_state("dn_1v2", ST_D1V2, 4);
        expect_state("dn_1v8", ST_D1V8, 4);
        expect_state("dn_3v3", ST_D3V3, 4);
        expect_state("dn_off", ST_OFF, 2);

        // Abort during U1V8: req=0 sampled at edge 7.
        pwr_req = 1'b1;
        expect_state("ab_3v3", ST_U3V3, 4);
        expect_state("ab_1v8", ST_U1V8, 3);
        pwr_req = 1'b0;
        expect_state("ab_d1v8", ST_D1V8, 4);
        expect_state("ab_d3v3", ST_D3V3, 4);
        expect_state("ab_off", ST_OFF, 2);

        // Request returns during D_INCK: teardown completes, then a fresh full sequence.
        pwr_req = 1'b1;
        full_up("re");
        pwr_req = 1'b0;
        expect_state("re_dxclr", ST_DXCLR, 4);
        expect_state("re_dinck_a", ST_DINCK, 2);
        pwr_req = 1'b1;
        expect_state("re_dinck_b", ST_DINCK, 2);
        expect_state("re_d1v2", ST_D1V2, 4);
        expect_state("re_d1v8", ST_D1V8, 4);
        expect_state("re_d3v3", ST_D3V3, 4);
        expect_state("re_off", ST_OFF, 1);
        expect_state("re2_3v3", ST_U3V3, 4);
        expect_state("re2_1v8", ST_U1V8, 4);
        expect_state("re2_1v2", ST_U1V2, 3);
        expect_state("re2_inck", ST_UINCK, 2);

        // Async reset mid-UINCK: outputs drop before the next clock edge.
        #2 reset_reset_n = 1'b0;
        #1 chk("async_rst", 11'b0);
        expect_state("rst_hold", ST_OFF, 2);
        reset_reset_n = 1'b1;
        expect_state("rst_3v3", ST_U3V3, 4);
        expect_state("rst_1v8", ST_U1V8, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sensor_pwr_seq.md
Name: sensor_pwr_seq

Overview:
- Hardware power-up/power-down sequencer for the SLVS-EC image sensor.
- Takes a single power request from a Nios II PIO bit and drives, in a fixed order with cycle-accurate gaps, the three regulator enables, the INCK oscillator enable and XCLR.
- Sits directly downstream of the Nios II subsystem and replaces software bit-banging of those pins, so firmware only sets pwr_req and polls pwr_good before starting SPI register writes.

Parameters:
- CNT_W, 24, dwell counter width; every T_* parameter must satisfy 1 <= T_* < 2^CNT_W.
- T_RAIL, 5000, cycles between consecutive rail or control edges (also used for every power-down step).
- T_INCK, 5000, cycles from 1V2 enable to INCK enable.
- T_XCLR, 1000, cycles from INCK enable to XCLR release.
- T_READY, 50000, cycles from XCLR release to pwr_good.

Ports:
- clk_clk  in  1  system clock; also the timing base for every delay.
- reset_reset_n  in  1  asynchronous active-low reset.
- pwr_req  in  1  level: 1 = sensor powered, 0 = sensor off; synchronous to clk_clk.
- reg_3v3_en_o  out  1  3V3 regulator enable.
- reg_1v8_en_o  out  1  1V8 regulator enable.
- reg_1v2_en_o  out  1  1V2 regulator enable.
- inck_en_o  out  1  sensor input clock enable.
- xclr_o  out  1  sensor XCLR; 0 = sensor held in clear.
- pwr_good  out  1  sensor powered and released, SPI access allowed.
- busy  out  1  sequence in progress.
- state_o  out  4  current state encoding, for PIO readback/debug.

Behaviour:
- All outputs are registered. Every output is 0 during and after reset, and state is OFF.
- Reset asserted mid-sequence drops all outputs to 0 immediately (asynchronous).
- States and encodings:
  - OFF=0, U3V3=1, U1V8=2, U1V2=3, UINCK=4, UXCLR=5, ON=6
  - D_XCLR=7, D_INCK=8, D_1V2=9, D_1V8=10, D_3V3=11
- Dwell counter:
  - Cleared on every state entry.
  - A timed state exits when the count reaches dwell-1, so the state lasts exactly its dwell in cycles.
- Dwell per state:
  - U3V3, U1V8: T_RAIL.
  - U1V2: T_INCK.
  - UINCK: T_XCLR.
  - UXCLR: T_READY.
  - All D_* states: T_RAIL.
- Output changes take effect on the same edge that enters the state:
  - U3V3 sets 3V3; U1V8 sets 1V8; U1V2 sets 1V2; UINCK sets inck_en; UXCLR sets xclr; ON sets pwr_good.
  - D_XCLR clears xclr and pwr_good; D_INCK clears inck_en; D_1V2, D_1V8 and D_3V3 clear their rails.
  - D_3V3 exits to OFF after its dwell.
- OFF exits to U3V3 on the edge that samples pwr_req=1 (1-cycle latency). ON exits to D_XCLR on the edge that samples pwr_req=0.
- Abort while powering up: pwr_req=0 sampled in any U* state ends the current dwell and reverses on the next edge, tearing down only what is on:
  - U3V3 to D_3V3; U1V8 to D_1V8; U1V2 to D_1V2; UINCK to D_INCK; UXCLR to D_XCLR.
- Request returns while powering down: pwr_req=1 during D_* states is ignored. The sequence completes to OFF and then restarts from OFF if pwr_req is still 1, with no direct D_* to U* path.
- A pwr_req pulse shorter than one cycle-sample has no effect. Any pulse sampled high starts the sequence.
- busy = 1 in every state except OFF and ON. pwr_good = 1 only in ON.
- Illegal state encodings go to D_XCLR (safe teardown).
- Invariant: xclr_o=1 implies inck_en_o and all rails are 1. No rail is ever enabled out of order.

Test Plan:
All scenarios use T_RAIL=4, T_INCK=3, T_XCLR=5, T_READY=6.

- Reset release, pwr_req=0 for 20 cycles -> all outputs 0, state_o=0, busy=0.
- pwr_req rises and is sampled at edge 0 -> outputs rise in order: 3V3 at 1, 1V8 at 5, 1V2 at 9, inck at 12, xclr at 17, pwr_good at 23. busy=1 over cycles 1..22, then 0.
- From ON, pwr_req=0 sampled at edge m -> falls in order: xclr and pwr_good at m+1, inck at m+5, 1V2 at m+9, 1V8 at m+13, 3V3 at m+17. state_o=0 and busy=0 at m+21.
- Abort: pwr_req=0 sampled at edge 7 (during U1V8) -> 1V8 falls at 8, 3V3 falls at 12, OFF at 16. 1V2, inck and xclr never assert.
- pwr_req toggled 0 then back to 1 during D_INCK -> teardown completes to OFF, then a fresh up-sequence starts one cycle later with full dwells.
- reset_reset_n asserted mid-UINCK -> all outputs 0 asynchronously, before the next clock edge. After release with pwr_req=1, the sequence restarts at U3V3.
